// File: rtl/fact_pkg.sv
// Shared types for the factorial accelerator control unit: FSM states,
// datapath control word and the largest operand whose factorial fits 32 bits.
package fact_pkg;

    localparam int unsigned N_W   = 4;
    localparam int unsigned N_MAX = 12;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        INIT = 3'd1,
        CHK  = 3'd2,
        MUL  = 3'd3,
        DEC  = 3'd4,
        DONE = 3'd5,
        ERR  = 3'd6
    } state_e;

    typedef struct packed {
        logic ld;
        logic ud;
        logic ce;
        logic cntrst;
        logic regld;
        logic muxsel1;
        logic muxsel2;
        logic bufen;
    } ctrl_t;

    // Idle/reset control word: only the counter clear is asserted
    localparam ctrl_t CTRL_IDLE = ctrl_t'(8'b0001_0000);

endpackage

// File: rtl/fact_cu_dec.sv
// State-to-control decoder for fact_cu. Pure combinational Moore decode.
// Optional feature macro: FACT_CU_RANGE_CHK_EN (enables the ERR state decode).
import fact_pkg::*;

module fact_cu_dec (
    input  state_e i_state,
    output ctrl_t  o_ctrl,
    output logic   o_busy,
    output logic   o_done,
    output logic   o_err
);

    // Decode datapath strobes and host status for a given state
    always_comb begin
        o_ctrl = CTRL_IDLE;
        o_busy = 1'b0;
        o_done = 1'b0;
        o_err  = 1'b0;
        case (i_state)
            IDLE: begin
                o_ctrl = CTRL_IDLE;
            end
            INIT: begin
                o_ctrl         = '0;
                o_ctrl.ld      = 1'b1;
                o_ctrl.ce      = 1'b1;
                o_ctrl.regld   = 1'b1;
                o_ctrl.muxsel2 = 1'b1;
                o_busy         = 1'b1;
            end
            CHK: begin
                o_ctrl         = '0;
                o_ctrl.muxsel1 = 1'b1;
                o_busy         = 1'b1;
            end
            MUL: begin
                o_ctrl         = '0;
                o_ctrl.regld   = 1'b1;
                o_busy         = 1'b1;
            end
            DEC: begin
                o_ctrl         = '0;
                o_ctrl.ce      = 1'b1;
                o_busy         = 1'b1;
            end
            DONE: begin
                o_ctrl         = '0;
                o_ctrl.bufen   = 1'b1;
                o_busy         = 1'b1;
                o_done         = 1'b1;
            end
`ifdef FACT_CU_RANGE_CHK_EN
            ERR: begin
                o_ctrl         = '0;
                o_busy         = 1'b1;
                o_done         = 1'b1;
                o_err          = 1'b1;
            end
`endif
            default: begin
                o_ctrl = CTRL_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/fact_cu.sv
// Factorial accelerator control unit: four-phase go/done handshake and
// Moore sequencing of the counter / product-register datapath.
// Optional feature macro: FACT_CU_RANGE_CHK_EN (n > N_MAX reports err
// instead of computing).
import fact_pkg::*;

module fact_cu (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           go,
    input  logic [N_W-1:0] n,
    input  logic           greater,
    output logic           LD,
    output logic           UD,
    output logic           CE,
    output logic           CNTRST,
    output logic           REGLD,
    output logic           MUXSEL1,
    output logic           MUXSEL2,
    output logic           BUFEN,
    output logic           busy,
    output logic           done,
    output logic           err
);

    state_e r_state;
    state_e w_next;
    ctrl_t  r_ctrl;
    ctrl_t  w_ctrl;
    logic   r_busy;
    logic   r_done;
    logic   r_err;
    logic   w_busy;
    logic   w_done;
    logic   w_err;

`ifndef FACT_CU_RANGE_CHK_EN
    // Operand only matters to the range check; keep it visibly consumed
    logic   w_unused_n;
    assign  w_unused_n = ^n;
`endif

    // Next-state logic; unused encodings fall back to IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (go) begin
                    w_next = INIT;
`ifdef FACT_CU_RANGE_CHK_EN
                    if (32'(n) > N_MAX) begin
                        w_next = ERR;
                    end
`endif
                end
            end
            INIT:    w_next = CHK;
            CHK:     w_next = greater ? MUL : DONE;
            MUL:     w_next = DEC;
            DEC:     w_next = CHK;
            DONE:    w_next = go ? DONE : IDLE;
`ifdef FACT_CU_RANGE_CHK_EN
            ERR:     w_next = go ? ERR : IDLE;
`endif
            default: w_next = IDLE;
        endcase
    end

    // Decode the upcoming state so registered outputs track the state register
    fact_cu_dec u_dec (
        .i_state (w_next),
        .o_ctrl  (w_ctrl),
        .o_busy  (w_busy),
        .o_done  (w_done),
        .o_err   (w_err)
    );

    // State register and registered outputs; reset forces IDLE values at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ctrl  <= CTRL_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ctrl  <= w_ctrl;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_err   <= w_err;
        end
    end

    assign LD      = r_ctrl.ld;
    assign UD      = r_ctrl.ud;
    assign CE      = r_ctrl.ce;
    assign CNTRST  = r_ctrl.cntrst;
    assign REGLD   = r_ctrl.regld;
    assign MUXSEL1 = r_ctrl.muxsel1;
    assign MUXSEL2 = r_ctrl.muxsel2;
    assign BUFEN   = r_ctrl.bufen;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;

endmodule

// File: tb/tb_fact_cu.sv
// Directed bench for fact_cu paired with a small behavioural factorial datapath.
module tb_fact_cu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        go;
    logic [3:0]  n;
    logic        greater;
    logic        LD, UD, CE, CNTRST, REGLD, MUXSEL1, MUXSEL2, BUFEN;
    logic        busy, done, err;

    logic [3:0]  dp_cnt;
    logic [31:0] dp_prod;
    logic [31:0] bufout;
    logic [10:0] outs;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fact_cu dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .go      (go),
        .n       (n),
        .greater (greater),
        .LD      (LD),
        .UD      (UD),
        .CE      (CE),
        .CNTRST  (CNTRST),
        .REGLD   (REGLD),
        .MUXSEL1 (MUXSEL1),
        .MUXSEL2 (MUXSEL2),
        .BUFEN   (BUFEN),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    // Datapath: down-counter, product register, comparator and output buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_cnt  <= 4'd0;
            dp_prod <= 32'd0;
        end else begin
            if (CNTRST)       dp_cnt <= 4'd0;
            else if (CE) begin
                if (LD)       dp_cnt <= n;
                else if (UD)  dp_cnt <= dp_cnt + 4'd1;
                else          dp_cnt <= dp_cnt - 4'd1;
            end
            if (REGLD)        dp_prod <= MUXSEL2 ? 32'd1 : dp_prod * 32'(dp_cnt);
        end
    end

    assign greater = MUXSEL1 && (dp_cnt > 4'd1);
    assign bufout  = BUFEN ? dp_prod : 32'd0;
    assign outs    = {LD, UD, CE, CNTRST, REGLD, MUXSEL1, MUXSEL2, BUFEN, busy, done, err};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // One handshake transaction; drop_at = 0 holds go through DONE
    task automatic run(input string tag, input logic [3:0] nv, input int exp_edges,
                       input logic [31:0] exp_buf, input logic exp_err,
                       input int exp_ld, input int exp_regld, input int drop_at);
        int          edges;
        int          ld_cnt;
        int          regld_cnt;
        int          bad_bufen;
        int          bad_ud;
        int          bad_busy;
        logic        got;
        logic        err_seen;
        logic [31:0] buf_seen;
        edges = 0; ld_cnt = 0; regld_cnt = 0; bad_bufen = 0; bad_ud = 0; bad_busy = 0;
        got = 1'b0; err_seen = 1'b0; buf_seen = 32'd0;
        @(negedge clk);
        n  = nv;
        go = 1'b1;
        while (!got && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
            if (LD)            ld_cnt++;
            if (REGLD)         regld_cnt++;
            if (BUFEN && !done) bad_bufen++;
            if (UD)            bad_ud++;
            if (!busy)         bad_busy++;
            if (edges == drop_at) go = 1'b0;
            if (done) begin
                got      = 1'b1;
                buf_seen = bufout;
                err_seen = err;
            end
        end
        check({tag, " done_edge"}, 32'(edges), 32'(exp_edges));
        check({tag, " bufout"},    buf_seen, exp_buf);
        check({tag, " err"},       32'(err_seen), 32'(exp_err));
        check({tag, " ld_pulses"}, 32'(ld_cnt), 32'(exp_ld));
        check({tag, " regld_pulses"}, 32'(regld_cnt), 32'(exp_regld));
        check({tag, " bufen_outside_done"}, 32'(bad_bufen), 32'd0);
        check({tag, " ud_high"},   32'(bad_ud), 32'd0);
        check({tag, " busy_low_in_run"}, 32'(bad_busy), 32'd0);
        if (drop_at == 0) begin
            @(posedge clk); #1;
            check({tag, " done_held"}, 32'(done), 32'd1);
            @(negedge clk);
            go = 1'b0;
        end
        @(posedge clk); #1;
        check({tag, " idle_outputs"}, 32'(outs), 32'h080);
    endtask

    initial begin
        int  k;
        logic found;
        rst_n = 1'b0;
        go    = 1'b1;
        n     = 4'd5;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'(outs), 32'h080);
        @(negedge clk);
        go    = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_release", 32'(outs), 32'h080);

        run("n5",  4'd5,  15, 32'd120,       1'b0, 1, 5,  0);
        run("n0",  4'd0,  3,  32'd1,         1'b0, 1, 1,  0);
        run("n1",  4'd1,  3,  32'd1,         1'b0, 1, 1,  0);
        run("n2",  4'd2,  6,  32'd2,         1'b0, 1, 2,  0);
        run("n12", 4'd12, 36, 32'd479001600, 1'b0, 1, 12, 0);
`ifdef FACT_CU_RANGE_CHK_EN
        run("n13", 4'd13, 1,  32'd0,         1'b1, 0, 0,  0);
`else
        run("n13", 4'd13, 39, 32'd1932053504, 1'b0, 1, 13, 0);
`endif
        run("drop", 4'd5, 15, 32'd120,       1'b0, 1, 5,  4);

        // Reset asserted while the n = 6 run sits in MUL
        @(negedge clk);
        n     = 4'd6;
        go    = 1'b1;
        found = 1'b0;
        k     = 0;
        while (!found && k < 50) begin
            @(posedge clk); #1;
            k++;
            if (REGLD && !MUXSEL2) found = 1'b1;
        end
        check("reach_mul", 32'(found), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'(outs), 32'h080);
        go = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run("n3_after_reset", 4'd3, 9, 32'd6, 1'b0, 1, 3, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fact_cu.md
# fact_cu

Control unit for the factorial accelerator. It sequences the factorial datapath (down-counter, comparator, product register, operand muxes, output buffer) to compute n! for a 4-bit n. It exposes a four-phase go/done handshake to the host and drives every datapath control strobe from a Moore state machine. It sits beside the datapath inside the accelerator top level, replacing hand-driven control.

## Interface
- N_MAX, 12: largest n whose factorial fits the 32-bit product register; used only by the range check.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- go  in  1  host start request; level-sensitive, four-phase handshake.
- n  in  4  operand; host holds it stable from go rise until done rise.
- greater  in  1  datapath comparator output; 1 when counter value > 1.
- LD  out  1  counter parallel load.
- UD  out  1  counter direction (1 = up, 0 = down); this block always drives 0.
- CE  out  1  counter enable.
- CNTRST  out  1  counter synchronous clear.
- REGLD  out  1  product register load.
- MUXSEL1  out  1  routes counter to comparator.
- MUXSEL2  out  1  product register input select (1 = constant 1, 0 = product × count).
- BUFEN  out  1  output buffer drive enable.
- busy  out  1  high in every state except IDLE.
- done  out  1  result valid or error reported.
- err  out  1  range error; valid while done = 1.

## Operation
- Reset: state goes to IDLE. All outputs are 0 except CNTRST = 1.
- Outputs are decoded purely from the state register (Moore). Any control not listed for a state is 0.
- IDLE: CNTRST = 1. When go = 1 → INIT, or → ERR when the range check is compiled in and n > N_MAX.
- INIT: LD = 1, CE = 1 (counter ← n), REGLD = 1, MUXSEL2 = 1 (product ← 1). → CHK.
- CHK: MUXSEL1 = 1. If greater = 1 → MUL, else → DONE.
- MUL: REGLD = 1, MUXSEL2 = 0 (product ← product × count). → DEC.
- DEC: CE = 1, UD = 0 (count − 1). → CHK.
- DONE: BUFEN = 1, done = 1. Holds until go = 0, then → IDLE.
- ERR: done = 1, err = 1, BUFEN = 0. Holds until go = 0, then → IDLE.
- go is ignored outside IDLE, DONE and ERR. Dropping go mid-run does not abort.
- go still high on the cycle DONE/ERR exits is not possible, because exit requires go = 0. A new request needs go to rise again from IDLE.
- n = 0 and n = 1 both yield product 1 (CHK sees greater = 0 immediately).
- rst_n low in any state forces IDLE and the reset output values immediately. An in-flight computation is discarded.
- Unused state encodings decode to IDLE outputs and transition to IDLE.

## Timing
- The state register updates on the rising edge of clk.
- IDLE→INIT occurs on the first edge with go = 1.
- Edges from go sampled to done = 1: 3 for n ≤ 1, 3n for 2 ≤ n ≤ N_MAX (n = 5 → 15, n = 12 → 36).
- ERR is entered on the first edge with go = 1 (done after 1 edge).
- done falls on the first edge after go = 0.
- busy is high from INIT through DONE/ERR inclusive.

## Configuration
- FACT_CU_RANGE_CHK_EN defined: IDLE compares n against N_MAX. n > N_MAX goes to ERR and the datapath is never strobed.
- Undefined: the ERR state and the err logic are omitted. err is tied to 0. All n take the INIT path, and results for n > 12 are the product truncated mod 2^32.

## Structure
- Shared package fact_pkg holds:
  - the state enum (IDLE, INIT, CHK, MUL, DEC, DONE, ERR);
  - a packed control-word typedef grouping LD, UD, CE, CNTRST, REGLD, MUXSEL1, MUXSEL2, BUFEN;
  - the N_MAX default.
- One sub-module, fact_cu_dec, maps state to control word combinationally. The state register and next-state logic stay in fact_cu.

## Test plan
- Reset: rst_n low with go = 1 → state IDLE; CNTRST = 1, all other outputs 0; busy = 0.
- Pair with the datapath, n = 5, go held → done at edge 15; bufout = 120; err = 0; BUFEN = 1 only in DONE.
- n = 0 and n = 1 → done at edge 3; bufout = 1; MUL is never visited (REGLD pulses exactly once).
- n = 12 → done at edge 36; bufout = 479001600. With FACT_CU_RANGE_CHK_EN, n = 13 → done = 1, err = 1 at edge 1, LD/REGLD never asserted. Without it, n = 13 → bufout = 1932053504.
- Handshake: go dropped at edge 4 of an n = 5 run → computation completes at edge 15, done pulses, IDLE next edge. go held through DONE → done stays 1 until go falls.
- Reset mid-run: rst_n low during MUL of n = 6 → outputs return to reset values asynchronously. A subsequent go with n = 3 → bufout = 6 at edge 9.
